hazard_sequencer: RTL and testbench

- Pipeline hazard and sequencing unit for the 5-stage MIPS core (F/D/E/M/W).
- Produces forwarding selects for the E-stage ALU and the D-stage branch comparator.
- Produces stall/flush controls for load-use and branch-operand hazards.
- Sequences a multi-cycle MULT/DIV unit with a busy FSM, interlocking later mult/div and MFHI/MFLO instructions until HI/LO is written.

---
 rtl/hazard_sequencer.sv | 151 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: hazard and sequencing unit for the 5-stage MIPS core.
//   - E-stage ALU forwarding selects (forwardAE/BE: 10 = M, 01 = W, 00 = regfile)
//   - D-stage branch comparator forwarding from M (forwardAD/BD)
//   - stall/flush for load-use, branch-operand and mult/div interlocks
//   - mult/div busy FSM producing md_busy and a one-cycle hilo_we strobe
// Ports:
//   clk, reset                 core clock, synchronous active-low reset
//   rsD/rtD, rsE/rtE           source registers in D and E
//   writereg*/regwrite*        destination and write enable in E, M, W
//   memtoregE/M                load in E / M
//   branchD, pcsrcD, jumpD     control-flow info resolved in D
//   mdopD, hiloreadD           mult/div op or MFHI/MFLO in D
//   mdstartE, mdisdivE         mult/div op in E, divide flag
//   forward*, stall*, flush*   hazard controls (combinational)
//   md_busy, hilo_we           mult/div occupancy and HI/LO write strobe
module hazard_sequencer #(
  parameter int REGW       = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            pcsrcD,
  input  logic            jumpD,
  input  logic            mdopD,
  input  logic            hiloreadD,
  input  logic            mdstartE,
  input  logic            mdisdivE,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic            md_busy,
  output logic            hilo_we
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 2);

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ld;
  logic          lwstall, branchstall, mdstall, stall, busy_raw;

  // ---------------- hazard detection ----------------
  assign lwstall     = memtoregE && (hit(rtE, rsD) || hit(rtE, rtD));
  assign branchstall = branchD &&
                       ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                        (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
  assign busy_raw    = (state_q == BUSY) || ((state_q == IDLE) && mdstartE);
  assign mdstall     = busy_raw && (mdopD || hiloreadD);
  assign stall       = lwstall || branchstall || mdstall;

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushE    = 1'b0;
    flushD    = 1'b0;
    md_busy   = 1'b0;
    hilo_we   = 1'b0;
    if (reset) begin
      if      (regwriteM && hit(rsE, writeregM)) forwardAE = 2'b10;
      else if (regwriteW && hit(rsE, writeregW)) forwardAE = 2'b01;
      if      (regwriteM && hit(rtE, writeregM)) forwardBE = 2'b10;
      else if (regwriteW && hit(rtE, writeregW)) forwardBE = 2'b01;
      forwardAD = regwriteM && hit(rsD, writeregM);
      forwardBD = regwriteM && hit(rtD, writeregM);
      stallF    = stall;
      stallD    = stall;
      flushE    = stall;
      flushD    = (pcsrcD || jumpD) && !stall;
      md_busy   = busy_raw;
      hilo_we   = (state_q == DONE);
    end
  end

  // ---------------- mult/div sequencer ----------------
  // cnt holds the BUSY cycles still to run, including the current one, so the
  // op spends 1 IDLE/DONE start cycle + (N-2) BUSY cycles + 1 DONE cycle = N.
  // An op of length 2 skips BUSY entirely.
  // The start is cancelled only by hazards raised by the D-stage instruction;
  // the interlock raised by the md unit itself must not cancel the op it guards.
  always_comb begin
    ld      = mdisdivE ? DIV_LD : MUL_LD;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (mdstartE && !(lwstall || branchstall)) begin
        cnt_d   = ld;
        state_d = (ld == '0) ? DONE : BUSY;
      end
      BUSY: if (cnt_q <= CW'(1)) begin
        cnt_d   = '0;
        state_d = DONE;
      end else begin
        cnt_d   = cnt_q - 1'b1;
      end
      DONE: if (mdstartE) begin
        cnt_d   = ld;
        state_d = (ld == '0) ? DONE : BUSY;
      end else begin
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
  localparam int MUL = 4;
  localparam int DIV = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, pcsrcD, jumpD, mdopD, hiloreadD, mdstartE, mdisdivE;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, stallF, stallD, flushD, flushE, md_busy, hilo_we;

  int total = 0;
  int bad = 0;

  hazard_sequencer #(.REGW(5), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .mdopD(mdopD), .hiloreadD(hiloreadD), .mdstartE(mdstartE), .mdisdivE(mdisdivE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .md_busy(md_busy), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The mult/div unit is modelled as a deadline: once an op is accepted in
  // cycle t, it owns the unit until cycle t+N-1, where HI/LO is written.
  int cyc = 0;
  bit active = 1'b0;
  int done_at = 0;

  function automatic bit m(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic bit d_hazard();
    bit lw, br;
    lw = memtoregE && (m(rtE, rsD) || m(rtE, rtD));
    br = branchD && ((regwriteE && (m(writeregE, rsD) || m(writeregE, rtD))) ||
                     (memtoregM && (m(writeregM, rsD) || m(writeregM, rtD))));
    return lw || br;
  endfunction

  function automatic bit exp_busy();
    if (active) return cyc != done_at;
    return mdstartE;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [1:0] fa, fb;
    bit st, busy, hw;
    if (!reset) return 12'h000;
    fa = (regwriteM && m(rsE, writeregM)) ? 2'b10 : (regwriteW && m(rsE, writeregW)) ? 2'b01 : 2'b00;
    fb = (regwriteM && m(rtE, writeregM)) ? 2'b10 : (regwriteW && m(rtE, writeregW)) ? 2'b01 : 2'b00;
    busy = exp_busy();
    hw   = active && (cyc == done_at);
    st   = d_hazard() || (busy && (mdopD || hiloreadD));
    return {fa, fb, regwriteM && m(rsD, writeregM), regwriteM && m(rtD, writeregM),
            st, st, (pcsrcD || jumpD) && !st, st, busy, hw};
  endfunction

  always @(posedge clk) begin
    if (!reset) active = 1'b0;
    else if (mdstartE && (active ? (cyc == done_at) : !d_hazard())) begin
      active  = 1'b1;
      done_at = cyc + (mdisdivE ? DIV : MUL) - 1;
    end else if (active && cyc == done_at) active = 1'b0;
    cyc++;
  end

  // Every-cycle compare against the model, mid-cycle with inputs settled.
  always @(negedge clk) begin
    logic [11:0] act, want;
    act  = {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, flushD, flushE, md_busy, hilo_we};
    want = exp_vec();
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL model cyc=%0d got=%03h want=%03h", cyc, act, want);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, pcsrcD, jumpD, mdopD, hiloreadD, mdstartE, mdisdivE} = '0;
  endtask

  int pulses;

  initial begin
    clr();
    reset = 1'b0;
    // reset state: forwarding conditions present but outputs forced low
    rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; mdstartE = 1'b1;
    #2;
    chk("rst_fwdAE", forwardAE, 0);
    chk("rst_busy", md_busy, 0);
    tick(); tick();
    clr(); reset = 1'b1;

    // 1. ALU forwarding
    tick();
    rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1;
    #2 chk("fwdAE_M", forwardAE, 2);
    regwriteM = 1'b0;
    #1 chk("fwdAE_W", forwardAE, 1);
    rsE = 5'd0; writeregM = 5'd0; regwriteM = 1'b1;
    #1 chk("fwdAE_r0", forwardAE, 0);

    // 2. load-use
    tick(); clr();
    memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #2 chk("lw_stall", {stallF, stallD, flushE}, 7);
    tick(); clr();
    #2 chk("lw_clear", {stallF, stallD, flushE}, 0);
    tick(); clr();
    rsE = 5'd5; writeregW = 5'd5; regwriteW = 1'b1;
    #2 chk("lw_fwdW", forwardAE, 1);

    // 3. branch hazard
    tick(); clr();
    branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd4; rtD = 5'd4; pcsrcD = 1'b1;
    #2 chk("br_stall", stallD, 1);
    chk("br_noflushD", flushD, 0);
    tick(); clr();
    branchD = 1'b1; rtD = 5'd4; writeregM = 5'd4; regwriteM = 1'b1;
    #2 chk("br_fwdBD", forwardBD, 1);
    chk("br_nostall", stallD, 0);
    pcsrcD = 1'b1;
    #1 chk("br_flushD", flushD, 1);

    // 4. multiply with MFHI waiting in D
    tick(); clr();
    mdstartE = 1'b1; hiloreadD = 1'b1;
    #2 chk("mul_c0_stall", stallD, 1);
    for (int c = 1; c <= 2; c++) begin
      tick(); mdstartE = 1'b0;
      #2 chk("mul_stall", stallD, 1);
      chk("mul_nowe", hilo_we, 0);
    end
    tick();
    #2 chk("mul_c3_we", hilo_we, 1);
    chk("mul_c3_stall", stallD, 0);
    tick();
    #2 chk("mul_c4_busy", md_busy, 0);
    chk("mul_c4_we", hilo_we, 0);

    // 5. divide followed back-to-back by multiply
    tick(); clr();
    mdstartE = 1'b1; mdisdivE = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick(); mdstartE = 1'b0; mdisdivE = 1'b0;
    end
    #2 chk("div_c30_we", hilo_we, 0);
    tick();
    mdstartE = 1'b1;
    #2 chk("div_c31_we", hilo_we, 1);
    chk("div_c31_busy", md_busy, 0);
    tick(); mdstartE = 1'b0;
    #2 chk("b2b_c32_busy", md_busy, 1);
    tick();
    #2 chk("b2b_c33_we", hilo_we, 0);
    tick();
    #2 chk("b2b_c34_we", hilo_we, 1);
    tick();
    #2 chk("b2b_c35_busy", md_busy, 0);

    // 6. reset in the middle of a divide
    tick(); clr();
    mdstartE = 1'b1; mdisdivE = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(); mdstartE = 1'b0; mdisdivE = 1'b0;
    end
    reset = 1'b0;
    tick(); reset = 1'b1;
    #2 chk("rstdiv_busy", md_busy, 0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #2 if (hilo_we) pulses++;
    end
    chk("rstdiv_nowe", pulses, 0);

    // random phase, checked against the model every cycle
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset     = ($urandom_range(0, 63) != 0);
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom);
      regwriteM = 1'($urandom);
      regwriteW = 1'($urandom);
      memtoregE = ($urandom_range(0, 3) == 0);
      memtoregM = ($urandom_range(0, 3) == 0);
      branchD   = ($urandom_range(0, 3) == 0);
      pcsrcD    = 1'($urandom);
      jumpD     = ($urandom_range(0, 7) == 0);
      mdopD     = ($urandom_range(0, 3) == 0);
      hiloreadD = ($urandom_range(0, 3) == 0);
      mdstartE  = ($urandom_range(0, 5) == 0);
      mdisdivE  = ($urandom_range(0, 3) == 0);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
